// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital clock core: digit limits,
// digit-select patterns, segment constants and 12-hour conversion.
package clock_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef bcd_t digits_t [NUM_DIGITS];

  // Digit positions in display order, followed by the two non-digit slots.
  typedef enum logic [2:0] {
    SLOT_H_TEN = 3'd0,
    SLOT_H_ONE = 3'd1,
    SLOT_M_TEN = 3'd2,
    SLOT_M_ONE = 3'd3,
    SLOT_S_TEN = 3'd4,
    SLOT_S_ONE = 3'd5,
    SLOT_PM    = 3'd6,
    SLOT_BLANK = 3'd7
  } slot_e;

  // Largest legal value per position, H_ten first.
  localparam bcd_t DIGIT_MAX [NUM_DIGITS] = '{4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
  localparam bcd_t H_ONE_MAX_AT_20 = 4'd3;

  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP      = 8'h80;
  localparam logic [7:0] SEG_COM_OFF = 8'hFF;

  // Active-low digit selects per slot; slot 0 drives the leftmost digit (bit 7).
  localparam logic [7:0] COM_PATTERNS [8] = '{
    8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  // True when code is a legal entry for position pos, given the hours-tens
  // digit already entered.
  function automatic logic digit_ok(input logic [2:0] pos, input bcd_t code,
                                    input bcd_t h_ten);
    bcd_t limit;
    limit = DIGIT_MAX[pos];
    if (pos == SLOT_H_ONE && h_ten == 4'd2) limit = H_ONE_MAX_AT_20;
    return code <= limit;
  endfunction

  // 24-hour BCD hours to 12-hour BCD hours {ten, one}: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [7:0] hours_12h(input bcd_t h_ten, input bcd_t h_one);
    logic [4:0] h;
    h = 5'(h_ten) * 5'd10 + 5'(h_one);
    if (h == 5'd0) begin
      h = 5'd12;
    end else if (h > 5'd12) begin
      h = h - 5'd12;
    end
    if (h >= 5'd10) return {4'd1, 4'(h - 5'd10)};
    return {4'd0, 4'(h)};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// BCD digit to seven-segment pattern, bit order {dp,g,f,e,d,c,b,a}, active-high.
// Codes above 9 decode to a dark digit.
module seg_decode
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digital_clock_core.sv
// Time-of-day clock with keypad time entry and a multiplexed 8-digit display.
// Time is kept as six BCD digits, 24-hour; 12-hour form exists only on the display.
module digital_clock_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_time,
  input  logic        mode_12h,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [23:0] time_bcd,
  output logic        pm,
  output logic        tick_1hz,
  output logic        entry_err,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int BW = (CLK_HZ / 2 > 1) ? $clog2(CLK_HZ / 2) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  digits_t       tm;
  digits_t       tm_inc;
  digits_t       buffer;
  digits_t       disp;
  logic [2:0]    idx;
  logic          set_prev;

  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    slot;

  logic          set_rise;
  logic          key_live;
  logic          key_digit;
  logic          key_good;
  logic [7:0]    h12;
  bcd_t          digit_sel;
  logic          blank_sel;
  logic [7:0]    seg_digit;
  logic [7:0]    seg_next;

  assign time_bcd = {tm[0], tm[1], tm[2], tm[3], tm[4], tm[5]};
  assign pm       = (tm[0] > 4'd1) || (tm[0] == 4'd1 && tm[1] >= 4'd2);

  // A key is only considered once set mode has been open for a full cycle;
  // the opening cycle itself is spent clearing the entry.
  assign set_rise  = set_time & ~set_prev;
  assign key_live  = set_time & set_prev & key_valid & (idx < 3'(NUM_DIGITS));
  assign key_digit = (key_code <= 4'd9);
  assign key_good  = digit_ok(idx, key_code, buffer[0]);

  // One-second increment with BCD carries; 23:59:59 wraps to 00:00:00.
  always_comb begin
    logic carry;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (a latch).
    tm_inc = tm;
    carry  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
      if (carry) begin
        if (tm[i] == DIGIT_MAX[i]) begin
          tm_inc[i] = '0;
        end else begin
          tm_inc[i] = tm[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
    if (carry) begin
      if (tm[0] == 4'd2 && tm[1] == H_ONE_MAX_AT_20) begin
        tm_inc[0] = '0;
        tm_inc[1] = '0;
      end else if (tm[1] == DIGIT_MAX[1]) begin
        tm_inc[0] = tm[0] + 4'd1;
        tm_inc[1] = '0;
      end else begin
        tm_inc[1] = tm[1] + 4'd1;
      end
    end
  end

  // Timekeeping and keypad entry. set_time has priority over a prescaler wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      set_prev  <= 1'b0;
      tick_1hz  <= 1'b0;
      entry_err <= 1'b0;
      // NOTE: the entry buffer is a handful of flops that must read as zeros after reset, so it is reset like any other register.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        tm[i]     <= '0;
        buffer[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      tick_1hz  <= 1'b0;
      entry_err <= 1'b0;
      set_prev  <= set_time;
      if (set_time) begin
        presc <= '0;
        if (set_rise) begin
          idx <= '0;
          for (int i = 0; i < NUM_DIGITS; i++) buffer[i] <= '0;
        end else if (key_live && key_digit) begin
          if (key_good) begin
            buffer[idx] <= key_code;
            idx         <= idx + 3'd1;
            if (idx == 3'(NUM_DIGITS - 1)) begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) tm[i] <= buffer[i];
              tm[NUM_DIGITS-1] <= key_code;
            end
          end else begin
            entry_err <= 1'b1;
          end
        end
      end else if (presc == PW'(CLK_HZ - 1)) begin
        presc    <= '0;
        tm       <= tm_inc;
        tick_1hz <= 1'b1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign h12 = hours_12h(tm[0], tm[1]);

  always_comb begin
    disp = tm;
    if (mode_12h) begin
      disp[0] = h12[7:4];
      disp[1] = h12[3:0];
    end
  end

  // During entry the buffer is shown up to idx; the digit at idx blinks and
  // everything to its right stays dark.
  always_comb begin
    digit_sel = '0;
    blank_sel = 1'b1;
    if (slot < SLOT_PM) begin
      if (set_time) begin
        digit_sel = buffer[slot];
        blank_sel = (slot > idx) || (slot == idx && !blink);
      end else begin
        digit_sel = disp[slot];
        blank_sel = 1'b0;
      end
    end
  end

  seg_decode u_seg_decode (
    .bcd (digit_sel),
    .seg (seg_digit)
  );

  always_comb begin
    seg_next = SEG_BLANK;
    if (slot == SLOT_PM) begin
      if (pm && mode_12h) seg_next = SEG_DP;
    end else if (!blank_sel) begin
      seg_next = seg_digit;
    end
  end

  // Scan sequencing, blink timebase and the registered display drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      slot      <= SLOT_H_TEN;
      blink_cnt <= '0;
      blink     <= 1'b0;
      seg_data  <= SEG_BLANK;
      seg_com   <= SEG_COM_OFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        slot     <= slot + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      if (blink_cnt == BW'(CLK_HZ / 2 - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
      seg_com  <= COM_PATTERNS[slot];
      seg_data <= seg_next;
    end
  end

endmodule
